// File: rtl/l2_arbiter_pkg.sv
// Shared types for the L2 request/answer arbiter.
// Requester ids, L2 channel bundles and answer routing helper.
package l2_arbiter_pkg;

  localparam int L2ARB_N_REQ     = 3;
  localparam int L2ARB_PADDR_W   = 32;
  localparam int L2ARB_LINE_W    = 128;
  localparam int L2ARB_WBB_TAG_W = 3;

  typedef enum logic [1:0] {
    L2ARB_IC  = 2'd0,
    L2ARB_DC  = 2'd1,
    L2ARB_PTW = 2'd2
  } l2arb_req_id_e;

  typedef enum logic [1:0] {
    l2arb_IReadLine  = 2'd0,
    l2arb_DReadLine  = 2'd1,
    l2arb_DWriteLine = 2'd2,
    l2arb_PTWLoad    = 2'd3
  } l2arb_req_type_e;

  typedef enum logic [2:0] {
    l2arb_s0_ILineRead    = 3'd0,
    l2arb_s0_DLineRead    = 3'd1,
    l2arb_s0_DLineWritten = 3'd2,
    l2arb_s0_DWbbWakeUp   = 3'd3,
    l2arb_s0_PTWLoad      = 3'd4
  } l2arb_ans_type_e;

  typedef struct packed {
    logic                       valid;
    l2arb_req_type_e            req_type;
    logic [L2ARB_WBB_TAG_W-1:0] wbb_tag;
    logic [L2ARB_PADDR_W-1:0]   paddr;
    logic [L2ARB_LINE_W-1:0]    line;
  } l2arb_l2c_req_t;

  typedef struct packed {
    logic                       valid;
    l2arb_ans_type_e            ans_type;
    logic [L2ARB_WBB_TAG_W-1:0] wbb_tag;
    logic [L2ARB_PADDR_W-1:0]   paddr;
    logic [L2ARB_LINE_W-1:0]    line;
  } l2c_l2arb_ans_t;

  // One-hot destination {PTW, DC, IC}; zero for an unknown type.
  function automatic logic [2:0] l2arb_ans_dest(input l2arb_ans_type_e t);
    logic [2:0] d;
    d = '0;
    case (t)
      l2arb_s0_ILineRead:    d = 3'b001;
      l2arb_s0_DLineRead,
      l2arb_s0_DLineWritten,
      l2arb_s0_DWbbWakeUp:   d = 3'b010;
      l2arb_s0_PTWLoad:      d = 3'b100;
      default:               d = 3'b000;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/l2_arbiter_rr.sv
// Three-way round-robin grant, searching from the slot after the last winner.
// Purely combinational; one-hot grant {PTW, DC, IC}.
module rr_arbiter3
  import l2_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt
);

  always_comb begin
    gnt = '0;
    unique case (last)
      L2ARB_IC: begin
        if (req[1])      gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      L2ARB_DC: begin
        if (req[2])      gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if (req[0])      gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/l2_arbiter.sv
// Shares the L2 request channel among I-cache, D-cache and PTW,
// and routes L2 answers back by type with outstanding-request limits.
module l2_arbiter
  import l2_arbiter_pkg::*;
#(
  parameter int MAX_OUTST = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  l2arb_l2c_req_t ic_req_i,
  output logic           ic_req_rdy_o,
  input  l2arb_l2c_req_t dc_req_i,
  output logic           dc_req_rdy_o,
  input  l2arb_l2c_req_t ptw_req_i,
  output logic           ptw_req_rdy_o,
  output l2arb_l2c_req_t l2arb_l2c_req_o,
  input  logic           l2c_l2arb_req_rdy_i,
  input  l2c_l2arb_ans_t l2c_l2arb_ans_i,
  output logic           l2arb_l2c_ans_rdy_o,
  output l2c_l2arb_ans_t ic_ans_o,
  output l2c_l2arb_ans_t dc_ans_o,
  output l2c_l2arb_ans_t ptw_ans_o,
  input  logic           ic_ans_rdy_i,
  input  logic           dc_ans_rdy_i,
  input  logic           ptw_ans_rdy_i
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  l2arb_l2c_req_t   req_q;
  logic [1:0]       owner_q;
  logic [1:0]       rr_q;
  logic [CNT_W-1:0] cnt_q [L2ARB_N_REQ];

  logic [2:0] vld;
  logic [2:0] pend;
  logic [2:0] elig;
  logic [2:0] arb_req;
  logic [2:0] gnt;
  logic [2:0] inc;
  logic [2:0] dec;
  logic [2:0] dst;
  logic       free;
  logic       hs_req;
  logic       ans_known;
  logic       hs_ans;

  assign vld    = {ptw_req_i.valid, dc_req_i.valid, ic_req_i.valid};
  assign free   = !req_q.valid || l2c_l2arb_req_rdy_i;
  assign hs_req = req_q.valid && l2c_l2arb_req_rdy_i;

  // The registered request counts against its owner until the L2 takes it.
  always_comb begin
    pend = '0;
    elig = '0;
    for (int i = 0; i < L2ARB_N_REQ; i++) begin
      pend[i] = req_q.valid && (owner_q == 2'(i));
      elig[i] = vld[i] &&
        (({1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, pend[i]}) < {1'b0, MAX_CNT});
    end
  end

  assign arb_req = elig & {3{free && !flush_i}};

  rr_arbiter3 u_rr (
    .req  (arb_req),
    .last (rr_q),
    .gnt  (gnt)
  );

  assign ic_req_rdy_o    = gnt[0];
  assign dc_req_rdy_o    = gnt[1];
  assign ptw_req_rdy_o   = gnt[2];
  assign l2arb_l2c_req_o = req_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_q   <= '0;
      owner_q <= L2ARB_IC;
      rr_q    <= L2ARB_PTW;
    end else if (flush_i) begin
      req_q.valid <= 1'b0;
    end else if (|gnt) begin
      unique case (1'b1)
        gnt[0]: begin
          req_q   <= ic_req_i;
          owner_q <= L2ARB_IC;
          rr_q    <= L2ARB_IC;
        end
        gnt[1]: begin
          req_q   <= dc_req_i;
          owner_q <= L2ARB_DC;
          rr_q    <= L2ARB_DC;
        end
        gnt[2]: begin
          req_q   <= ptw_req_i;
          owner_q <= L2ARB_PTW;
          rr_q    <= L2ARB_PTW;
        end
        default: ;
      endcase
    end else if (hs_req) begin
      req_q.valid <= 1'b0;
    end
  end

  assign dst       = l2arb_ans_dest(l2c_l2arb_ans_i.ans_type);
  assign ans_known = |dst;

  // Unknown answer types are drained so the L2 never stalls on them.
  assign l2arb_l2c_ans_rdy_o = ans_known ?
    |(dst & {ptw_ans_rdy_i, dc_ans_rdy_i, ic_ans_rdy_i}) : 1'b1;
  assign hs_ans = l2c_l2arb_ans_i.valid && l2arb_l2c_ans_rdy_o;

  always_comb begin
    ic_ans_o        = l2c_l2arb_ans_i;
    dc_ans_o        = l2c_l2arb_ans_i;
    ptw_ans_o       = l2c_l2arb_ans_i;
    ic_ans_o.valid  = l2c_l2arb_ans_i.valid && dst[0];
    dc_ans_o.valid  = l2c_l2arb_ans_i.valid && dst[1];
    ptw_ans_o.valid = l2c_l2arb_ans_i.valid && dst[2];
  end

  always_comb begin
    inc = '0;
    for (int i = 0; i < L2ARB_N_REQ; i++) begin
      inc[i] = hs_req && (owner_q == 2'(i));
    end
  end

  assign dec = {3{hs_ans}} & dst;

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < L2ARB_N_REQ; i++) begin
      if (rst_i || flush_i) begin
        cnt_q[i] <= '0;
      end else if (inc[i] && !dec[i]) begin
        if (cnt_q[i] != MAX_CNT) cnt_q[i] <= cnt_q[i] + 1'b1;
      end else if (dec[i] && !inc[i]) begin
        if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
      end
    end
  end

  a_ic_type: assert property (@(posedge clk_i) disable iff (rst_i)
    ic_req_i.valid |-> ic_req_i.req_type == l2arb_IReadLine);
  a_dc_type: assert property (@(posedge clk_i) disable iff (rst_i)
    dc_req_i.valid |-> (dc_req_i.req_type == l2arb_DReadLine ||
                        dc_req_i.req_type == l2arb_DWriteLine));
  a_ptw_type: assert property (@(posedge clk_i) disable iff (rst_i)
    ptw_req_i.valid |-> ptw_req_i.req_type == l2arb_PTWLoad);
  a_ans_known: assert property (@(posedge clk_i) disable iff (rst_i)
    l2c_l2arb_ans_i.valid |-> ans_known);

  for (genvar g = 0; g < L2ARB_N_REQ; g++) begin : g_cnt_chk
    a_dec_zero: assert property (@(posedge clk_i) disable iff (rst_i)
      (dec[g] && !inc[g]) |-> cnt_q[g] != '0);
    a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
      cnt_q[g] <= MAX_CNT);
  end

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: arbitration, limits, stalls,
// answer routing, flush and reset.
module tb_l2_arbiter;
  import l2_arbiter_pkg::*;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           flush_i;
  l2arb_l2c_req_t ic_req, dc_req, ptw_req, req_o;
  logic           ic_rdy, dc_rdy, ptw_rdy;
  logic           l2_rdy;
  l2c_l2arb_ans_t ans_i, ic_ans, dc_ans, ptw_ans;
  logic           ans_rdy_o;
  logic           ic_ans_rdy, dc_ans_rdy, ptw_ans_rdy;

  int n_checks = 0;
  int n_errors = 0;

  l2_arbiter #(.MAX_OUTST(4)) dut (
    .clk_i               (clk_i),
    .rst_i               (rst_i),
    .flush_i             (flush_i),
    .ic_req_i            (ic_req),
    .ic_req_rdy_o        (ic_rdy),
    .dc_req_i            (dc_req),
    .dc_req_rdy_o        (dc_rdy),
    .ptw_req_i           (ptw_req),
    .ptw_req_rdy_o       (ptw_rdy),
    .l2arb_l2c_req_o     (req_o),
    .l2c_l2arb_req_rdy_i (l2_rdy),
    .l2c_l2arb_ans_i     (ans_i),
    .l2arb_l2c_ans_rdy_o (ans_rdy_o),
    .ic_ans_o            (ic_ans),
    .dc_ans_o            (dc_ans),
    .ptw_ans_o           (ptw_ans),
    .ic_ans_rdy_i        (ic_ans_rdy),
    .dc_ans_rdy_i        (dc_ans_rdy),
    .ptw_ans_rdy_i       (ptw_ans_rdy)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic l2arb_l2c_req_t mkreq(input logic v,
      input l2arb_req_type_e t, input logic [31:0] a);
    l2arb_l2c_req_t r;
    r          = '0;
    r.valid    = v;
    r.req_type = t;
    r.wbb_tag  = 3'd5;
    r.paddr    = a;
    r.line     = {4{a}};
    return r;
  endfunction

  function automatic l2c_l2arb_ans_t mkans(input logic v,
      input l2arb_ans_type_e t);
    l2c_l2arb_ans_t r;
    r          = '0;
    r.valid    = v;
    r.ans_type = t;
    r.paddr    = 32'h0000_1234;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic chk_rdy(input string tag, input logic i, input logic d,
                         input logic p);
    check({tag, "_ic_rdy"}, 64'(ic_rdy), 64'(i));
    check({tag, "_dc_rdy"}, 64'(dc_rdy), 64'(d));
    check({tag, "_ptw_rdy"}, 64'(ptw_rdy), 64'(p));
  endtask

  task automatic chk_cnt(input string tag, input int i, input int d,
                         input int p);
    check({tag, "_cnt_ic"}, 64'(dut.cnt_q[0]), 64'(i));
    check({tag, "_cnt_dc"}, 64'(dut.cnt_q[1]), 64'(d));
    check({tag, "_cnt_ptw"}, 64'(dut.cnt_q[2]), 64'(p));
  endtask

  l2arb_l2c_req_t ic_r, dc_r, dc_w, dc_w2, ptw_r;

  initial begin
    ic_r  = mkreq(1'b1, l2arb_IReadLine, 32'h0000_0100);
    dc_r  = mkreq(1'b1, l2arb_DReadLine, 32'h0000_0200);
    ptw_r = mkreq(1'b1, l2arb_PTWLoad, 32'h0000_0300);
    dc_w  = mkreq(1'b1, l2arb_DWriteLine, 32'h8000_0040);
    dc_w2 = mkreq(1'b1, l2arb_DWriteLine, 32'h8000_0080);

    rst_i = 1'b1; flush_i = 1'b0; l2_rdy = 1'b1;
    ic_req = '0; dc_req = '0; ptw_req = '0; ans_i = '0;
    ic_ans_rdy = 1'b1; dc_ans_rdy = 1'b1; ptw_ans_rdy = 1'b1;
    tick(); tick();

    // k0: reset state, all three request, IC wins first
    rst_i = 1'b0;
    ic_req = ic_r; dc_req = dc_r; ptw_req = ptw_r;
    smp();
    check("rst_req_valid", 64'(req_o.valid), 64'(0));
    check("rst_req_paddr", 64'(req_o.paddr), 64'(0));
    chk_cnt("rst", 0, 0, 0);
    chk_rdy("k0", 1'b1, 1'b0, 1'b0);
    tick();
    smp();
    check("k1_type", 64'(req_o.req_type), 64'(l2arb_IReadLine));
    chk_rdy("k1", 1'b0, 1'b1, 1'b0);
    tick();
    smp();
    check("k2_type", 64'(req_o.req_type), 64'(l2arb_DReadLine));
    chk_rdy("k2", 1'b0, 1'b0, 1'b1);
    tick();
    smp();
    check("k3_type", 64'(req_o.req_type), 64'(l2arb_PTWLoad));
    check("k3_paddr", 64'(req_o.paddr), 64'(32'h300));
    chk_rdy("k3", 1'b1, 1'b0, 1'b0);
    tick();
    ic_req = '0; dc_req = '0; ptw_req = '0;
    smp();
    check("k4_paddr", 64'(req_o.paddr), 64'(32'h100));
    tick();

    // k5: IC again, then same-cycle inc/dec on IC counter
    ic_req = ic_r;
    smp();
    check("k5_valid", 64'(req_o.valid), 64'(0));
    chk_cnt("k5", 2, 1, 1);
    chk_rdy("k5", 1'b1, 1'b0, 1'b0);
    tick();
    ic_req = '0;
    ans_i = mkans(1'b1, l2arb_s0_ILineRead);
    smp();
    check("k6_ic_ans_v", 64'(ic_ans.valid), 64'(1));
    check("k6_dc_ans_v", 64'(dc_ans.valid), 64'(0));
    check("k6_ptw_ans_v", 64'(ptw_ans.valid), 64'(0));
    check("k6_ans_rdy", 64'(ans_rdy_o), 64'(1));
    check("k6_ptw_paddr", 64'(ptw_ans.paddr), 64'(32'h1234));
    tick();

    // k7..k9: PTW alone fills its budget
    ans_i = '0;
    ptw_req = ptw_r;
    smp();
    chk_cnt("k7", 2, 1, 1);
    check("k7_ptw_rdy", 64'(ptw_rdy), 64'(1));
    tick();
    smp();
    check("k8_ptw_rdy", 64'(ptw_rdy), 64'(1));
    tick();
    smp();
    check("k9_ptw_rdy", 64'(ptw_rdy), 64'(1));
    tick();
    ic_req = ic_r; dc_req = dc_r;
    smp();
    chk_rdy("k10", 1'b1, 1'b0, 1'b0);
    tick();
    ans_i = mkans(1'b1, l2arb_s0_PTWLoad);
    smp();
    check("k11_cnt_ptw", 64'(dut.cnt_q[2]), 64'(4));
    chk_rdy("k11", 1'b0, 1'b1, 1'b0);
    check("k11_ptw_ans_v", 64'(ptw_ans.valid), 64'(1));
    check("k11_ans_rdy", 64'(ans_rdy_o), 64'(1));
    tick();
    ans_i = '0;
    smp();
    check("k12_cnt_ptw", 64'(dut.cnt_q[2]), 64'(3));
    chk_rdy("k12", 1'b0, 1'b0, 1'b1);
    tick();
    ic_req = '0; dc_req = '0; ptw_req = '0;
    smp();
    check("k13_type", 64'(req_o.req_type), 64'(l2arb_PTWLoad));
    tick();

    // k14..k18: DC write-back with L2 stalled for three cycles
    l2_rdy = 1'b0;
    dc_req = dc_w;
    smp();
    chk_cnt("k14", 3, 2, 4);
    chk_rdy("k14", 1'b0, 1'b1, 1'b0);
    tick();
    dc_req = dc_w2; ic_req = ic_r;
    for (int s = 0; s < 3; s++) begin
      smp();
      check("stall_paddr", 64'(req_o.paddr), 64'(32'h8000_0040));
      check("stall_type", 64'(req_o.req_type), 64'(l2arb_DWriteLine));
      check("stall_line", 64'(req_o.line[63:0]), {2{32'h8000_0040}});
      chk_rdy("stall", 1'b0, 1'b0, 1'b0);
      tick();
    end
    l2_rdy = 1'b1;
    dc_req = '0; ic_req = '0;
    smp();
    check("k18_valid", 64'(req_o.valid), 64'(1));
    check("k18_cnt_dc", 64'(dut.cnt_q[1]), 64'(2));
    tick();

    // k19..k21: DC answer held off by the D-cache for two cycles
    ans_i = mkans(1'b1, l2arb_s0_DWbbWakeUp);
    dc_ans_rdy = 1'b0;
    smp();
    check("k19_valid", 64'(req_o.valid), 64'(0));
    check("k19_cnt_dc", 64'(dut.cnt_q[1]), 64'(3));
    for (int s = 0; s < 2; s++) begin
      check("wbb_dc_ans_v", 64'(dc_ans.valid), 64'(1));
      check("wbb_ic_ans_v", 64'(ic_ans.valid), 64'(0));
      check("wbb_ptw_ans_v", 64'(ptw_ans.valid), 64'(0));
      check("wbb_ans_rdy", 64'(ans_rdy_o), 64'(0));
      tick();
      smp();
    end
    dc_ans_rdy = 1'b1;
    #1;
    check("k21_ans_rdy", 64'(ans_rdy_o), 64'(1));
    check("k21_cnt_dc", 64'(dut.cnt_q[1]), 64'(3));
    tick();

    // k22..k24: flush with a pending request and an answer in flight
    ans_i = '0;
    l2_rdy = 1'b0;
    ic_req = ic_r;
    smp();
    check("k22_cnt_dc", 64'(dut.cnt_q[1]), 64'(2));
    check("k22_ic_rdy", 64'(ic_rdy), 64'(1));
    tick();
    flush_i = 1'b1; l2_rdy = 1'b1;
    dc_req = dc_r;
    ans_i = mkans(1'b1, l2arb_s0_DLineRead);
    smp();
    check("flush_req_valid", 64'(req_o.valid), 64'(1));
    chk_rdy("flush", 1'b0, 1'b0, 1'b0);
    check("flush_dc_ans_v", 64'(dc_ans.valid), 64'(1));
    check("flush_ans_rdy", 64'(ans_rdy_o), 64'(1));
    tick();
    flush_i = 1'b0;
    ans_i = '0; dc_req = '0;
    smp();
    check("post_flush_valid", 64'(req_o.valid), 64'(0));
    chk_cnt("post_flush", 0, 0, 0);
    check("post_flush_ic_rdy", 64'(ic_rdy), 64'(1));
    tick();

    // k25..k26: reset mid-stream restores pointer and state
    rst_i = 1'b1;
    ic_req = '0; dc_req = dc_r;
    smp();
    check("k25_valid", 64'(req_o.valid), 64'(1));
    tick();
    rst_i = 1'b0;
    ic_req = ic_r; dc_req = dc_r; ptw_req = ptw_r;
    smp();
    check("post_rst_valid", 64'(req_o.valid), 64'(0));
    check("post_rst_paddr", 64'(req_o.paddr), 64'(0));
    chk_cnt("post_rst", 0, 0, 0);
    chk_rdy("post_rst", 1'b1, 1'b0, 1'b0);
    tick();
    ic_req = '0; dc_req = '0; ptw_req = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
